iterative_shifter: RTL and testbench

Parametrised multi-cycle shifter for the ALU/execute path.
- Performs SLL, SRL, SRA or ROR on a WIDTH-bit operand.
- Moves at most STEP bit positions per clock, trading latency for area against a full log-stage barrel shifter.
- Sits behind a valid/ready handshake on both sides, so the execute stage can stall on it like any other multi-cycle unit.

---
 rtl/shift_pkg.sv | 24 ++
 rtl/shift_step_unit.sv | 46 ++++
 rtl/iterative_shifter.sv | 107 ++++++++++
 tb/tb_iterative_shifter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// ============================================================================
// shift_pkg : shared types for the iterative shifter
// Revision  : 1.0
// ============================================================================
`default_nettype none

package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } shift_state_e;

endpackage

`default_nettype wire

// File: rtl/shift_step_unit.sv
// ============================================================================
// shift_step_unit : combinational shift of one word by 0..STEP positions
// Revision        : 1.0
// ============================================================================
`default_nettype none

module shift_step_unit
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int AMT_W   = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  input  logic [1:0]       op_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0]   w_ones;
  logic [WIDTH-1:0]   w_srl;
  logic [WIDTH-1:0]   w_hi_mask;
  logic [SHAMT_W:0]   w_rot_amt;

  // amt == 0 makes the rotate-back distance WIDTH, which shifts to all zeros.
  assign w_ones    = '1;
  assign w_srl     = data_i >> amt_i;
  assign w_hi_mask = ~(w_ones >> amt_i);
  assign w_rot_amt = (SHAMT_W+1)'(WIDTH) - (SHAMT_W+1)'(amt_i);

  always_comb begin
    data_o = data_i;
    case (shift_op_e'(op_i))
      SH_SLL:  data_o = data_i << amt_i;
      SH_SRL:  data_o = w_srl;
      SH_SRA:  data_o = w_srl | (w_hi_mask & {WIDTH{sign_i}});
      SH_ROR:  data_o = w_srl | (data_i << w_rot_amt);
      default: data_o = data_i;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/iterative_shifter.sv
// ============================================================================
// iterative_shifter : multi-cycle SLL/SRL/SRA/ROR, at most STEP bits per clock
// Revision          : 1.0
// ============================================================================
`default_nettype none

module iterative_shifter
  import shift_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int STEP    = 4,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               busy
);

  localparam int                 AMT_W  = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

  shift_state_e       state_q, state_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic               sign_q, sign_d;

  logic [AMT_W-1:0]   w_amt;
  logic [WIDTH-1:0]   w_step;

  assign w_amt = (rem_q < STEP_C) ? AMT_W'(rem_q) : AMT_W'(STEP);

  shift_step_unit #(
    .WIDTH   (WIDTH),
    .STEP    (STEP),
    .SHAMT_W (SHAMT_W),
    .AMT_W   (AMT_W)
  ) u_step (
    .data_i  (work_q),
    .amt_i   (w_amt),
    .op_i    (op_q),
    .sign_i  (sign_q),
    .data_o  (w_step)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      work_q  <= '0;
      rem_q   <= '0;
      op_q    <= SH_SLL;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    rem_d   = rem_q;
    op_d    = op_q;
    sign_d  = sign_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          work_d  = in_data;
          rem_d   = in_shamt;
          op_d    = in_op;
          sign_d  = in_data[WIDTH-1];
          state_d = (in_shamt == '0) ? ST_DONE : ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        work_d = w_step;
        rem_d  = rem_q - SHAMT_W'(w_amt);
        if (rem_d == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == ST_IDLE) && !rst;
    out_valid = (state_q == ST_DONE);
    out_data  = work_q;
    busy      = (state_q != ST_IDLE);
  end

endmodule

`default_nettype wire

// File: tb/tb_iterative_shifter.sv
// ============================================================================
// tb_iterative_shifter : directed vector table plus handshake/reset sequences
// Revision             : 1.0
// ============================================================================
`default_nettype none

module tb_iterative_shifter;

  localparam int WIDTH = 32;
  localparam int STEP  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [4:0]  in_shamt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        busy;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  iterative_shifter #(.WIDTH(WIDTH), .STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] data;
    logic [4:0]  shamt;
    logic [31:0] exp;
    int          cyc;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_shift(input logic [1:0] op, input logic [31:0] d,
                                            input logic [4:0] s);
    case (op)
      2'b00:   return d << s;
      2'b01:   return d >> s;
      2'b10:   return $unsigned($signed(d) >>> s);
      default: return (s == 5'd0) ? d : ((d >> s) | (d << (6'd32 - {1'b0, s})));
    endcase
  endfunction

  // Issue one request, measure SHIFT cycles to out_valid, check result, then drain.
  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] d,
                        input logic [4:0] s, input logic [31:0] exp, input int cyc);
    int n;
    check({name, " in_ready"}, {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1; in_op = op; in_data = d; in_shamt = s;
    tick();
    in_valid = 1'b0; in_op = 2'($urandom); in_data = $urandom; in_shamt = 5'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    check({name, " latency"}, n, cyc);
    check({name, " data"}, out_data, exp);
    check({name, " busy"}, {31'b0, busy}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " drop"}, {30'b0, out_valid, busy}, 32'd0);
  endtask

  initial begin
    vecs[0]  = '{2'b10, 32'h80000000, 5'd31, 32'hFFFFFFFF, 8};
    vecs[1]  = '{2'b01, 32'h80000000, 5'd31, 32'h00000001, 8};
    vecs[2]  = '{2'b00, 32'h00000001, 5'd5,  32'h00000020, 2};
    vecs[3]  = '{2'b11, 32'h12345678, 5'd4,  32'h81234567, 1};
    vecs[4]  = '{2'b00, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0};
    vecs[5]  = '{2'b11, 32'hDEADBEEF, 5'd0,  32'hDEADBEEF, 0};
    vecs[6]  = '{2'b10, 32'h7FFFFFFF, 5'd31, 32'h00000000, 8};
    vecs[7]  = '{2'b10, 32'h80000000, 5'd1,  32'hC0000000, 1};
    vecs[8]  = '{2'b11, 32'h00000001, 5'd31, 32'h00000002, 8};
    vecs[9]  = '{2'b01, 32'hFFFFFFFF, 5'd16, 32'h0000FFFF, 4};
    vecs[10] = '{2'b00, 32'h0000FFFF, 5'd16, 32'hFFFF0000, 4};
    vecs[11] = '{2'b10, 32'hF0000000, 5'd7,  32'hFFE00000, 2};
    vecs[12] = '{2'b11, 32'h12345678, 5'd12, 32'h67812345, 3};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_shamt = '0; in_op = '0; out_ready = 1'b0;
    tick();
    tick();
    check("reset in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    #1;
    check("reset outputs", {out_data[29:0], out_valid, busy}, 32'd0);
    check("reset in_ready after", {31'b0, in_ready}, 32'd1);

    for (int i = 0; i < 13; i++)
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].data, vecs[i].shamt,
             vecs[i].exp, vecs[i].cyc);

    // Backpressure with a request queued behind the result.
    in_valid = 1'b1; in_op = 2'b00; in_data = 32'h1; in_shamt = 5'd5;
    tick();
    in_op = 2'b11; in_data = 32'h12345678; in_shamt = 5'd4;
    tick();
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp valid", {31'b0, out_valid}, 32'd1);
      check("bp data", out_data, 32'h00000020);
      check("bp in_ready", {31'b0, in_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp after hs", {30'b0, out_valid, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    check("bp queued accepted", {30'b0, busy, out_valid}, 32'd2);
    tick();
    check("bp queued valid", {31'b0, out_valid}, 32'd1);
    check("bp queued data", out_data, 32'h81234567);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset in the middle of SHIFT aborts the operation.
    in_valid = 1'b1; in_op = 2'b10; in_data = 32'hF0000000; in_shamt = 5'd20;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("rst in_ready low", {31'b0, in_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("rst abort out_valid", {31'b0, out_valid}, 32'd0);
    check("rst abort out_data", out_data, 32'd0);
    check("rst abort in_ready", {30'b0, in_ready, busy}, 32'd2);
    run_op("post-rst srl", 2'b01, 32'hF0000000, 5'd4, 32'h0F000000, 1);

    for (int i = 0; i < 300; i++) begin
      logic [1:0]  op;
      logic [31:0] d;
      logic [4:0]  s;
      op = 2'($urandom);
      d  = $urandom;
      s  = 5'($urandom);
      run_op("rand", op, d, s, ref_shift(op, d, s), (int'(s) + STEP - 1) / STEP);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
